// File: rtl/led_pattern_sequencer_if.sv
// CSR bus between the Nios II data master and the LED pattern sequencer.
// The CPU side uses the master modport and the sequencer uses the slave modport.
interface led_pattern_sequencer_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED animation engine. Software loads a pattern table, a step
// period and a run mode over the CSR slave. The sequencer then writes the
// patterns to the LED PIO through a zero-wait-state Avalon-MM master.
module led_pattern_sequencer #(
  parameter int DATA_W    = 8,
  parameter int NUM_STEPS = 8,
  parameter int PERIOD_W  = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  led_pattern_sequencer_if.slave  csr,
  output logic                    irq,
  output logic [1:0]              pio_address,
  output logic                    pio_chipselect,
  output logic                    pio_write_n,
  output logic [31:0]             pio_writedata
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                done_set;

  logic                enable_q;
  logic                one_shot_q;
  logic [2:0]          last_step_q;
  logic [PERIOD_W-1:0] period_q;
  logic                done_q;
  logic [DATA_W-1:0]   manual_q;
  logic                manual_pend_q;
  logic [DATA_W-1:0]   pattern_q [NUM_STEPS];

  logic                busy;
  logic                csr_wr;
  logic                wr_ctrl, wr_period, wr_status, wr_manual, wr_pattern;
  logic [DATA_W-1:0]   step_pattern;
  logic [DATA_W-1:0]   csr_pattern;
  logic                unused_wdata;

  assign csr_wr     = csr.chipselect & ~csr.write_n;
  assign wr_ctrl    = csr_wr && (csr.address == 4'd0);
  assign wr_period  = csr_wr && (csr.address == 4'd1);
  assign wr_status  = csr_wr && (csr.address == 4'd2);
  assign wr_manual  = csr_wr && (csr.address == 4'd3);
  assign wr_pattern = csr_wr && csr.address[3];

  assign busy         = (state_q == S_WRITE) || (state_q == S_WAIT);
  assign irq          = done_q;
  assign pio_address  = 2'd0;
  assign unused_wdata = ^csr.writedata;

  // Pattern selected by the current step; entries beyond the table read as 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    step_pattern = '0;
    if (int'(step_q) < NUM_STEPS) step_pattern = pattern_q[step_q[IDX_W-1:0]];
  end

  // Pattern selected by the CSR address for readback.
  always_comb begin
    csr_pattern = '0;
    if (int'(csr.address[2:0]) < NUM_STEPS) csr_pattern = pattern_q[csr.address[IDX_W-1:0]];
  end

  // Sequencer state, step index and period down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: step through the table and honour a disable while running.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && csr.writedata[0]) begin
          step_d  = 3'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // A period of 0 behaves like 1, so the counter starts at 0 in both cases.
        cnt_d   = (period_q == '0) ? '0 : period_q - 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // >= so that shrinking last_step below the current step still ends the pass.
          if (step_q >= last_step_q) begin
            if (one_shot_q) begin
              state_d = S_DONE;
            end else begin
              step_d  = 3'd0;
              state_d = S_WRITE;
            end
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_WRITE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        done_set = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling while running stops at once and leaves step visible for software.
    if (busy && wr_ctrl && !csr.writedata[0]) begin
      state_d = S_IDLE;
      step_d  = step_q;
      cnt_d   = cnt_q;
    end
  end

  // CSR bank, sticky done flag and the one-shot manual write request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      one_shot_q    <= 1'b0;
      last_step_q   <= 3'd0;
      period_q      <= PERIOD_W'(1);
      done_q        <= 1'b0;
      manual_q      <= '0;
      manual_pend_q <= 1'b0;
      // NOTE: the pattern table is software-visible CSR state, so it is reset like any other register.
      for (int i = 0; i < NUM_STEPS; i++) pattern_q[i] <= '0;
    end else begin
      manual_pend_q <= 1'b0;
      if (wr_ctrl) begin
        enable_q    <= csr.writedata[0];
        one_shot_q  <= csr.writedata[1];
        last_step_q <= csr.writedata[6:4];
      end
      if (done_set) enable_q <= 1'b0;
      if (wr_period) period_q <= csr.writedata[PERIOD_W-1:0];
      // Set has priority over a clear landing in the same cycle.
      if (wr_status && csr.writedata[8]) done_q <= 1'b0;
      if (done_set) done_q <= 1'b1;
      if (wr_manual && (state_q == S_IDLE)) begin
        manual_q      <= csr.writedata[DATA_W-1:0];
        manual_pend_q <= 1'b1;
      end
      if (wr_pattern && (int'(csr.address[2:0]) < NUM_STEPS))
        pattern_q[csr.address[IDX_W-1:0]] <= csr.writedata[DATA_W-1:0];
    end
  end

  // PIO master: one write cycle per WRITE state or pending manual request.
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    if (state_q == S_WRITE) begin
      pio_chipselect = 1'b1;
      pio_write_n    = 1'b0;
      pio_writedata  = 32'(step_pattern);
    end else if (manual_pend_q) begin
      pio_chipselect = 1'b1;
      pio_write_n    = 1'b0;
      pio_writedata  = 32'(manual_q);
    end
  end

  // Combinational CSR readback; unmapped addresses read 0.
  always_comb begin
    csr.readdata = '0;
    case (csr.address)
      4'd0:    csr.readdata = {25'd0, last_step_q, 2'b00, one_shot_q, enable_q};
      4'd1:    csr.readdata = 32'(period_q);
      4'd2:    csr.readdata = {23'd0, done_q, 1'b0, step_q, 3'b000, busy};
      4'd3:    csr.readdata = 32'(manual_q);
      default: if (csr.address[3]) csr.readdata = 32'(csr_pattern);
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for the LED pattern sequencer: drives the CSR bus, records
// every PIO write with its cycle number, and compares against hand-computed values.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        irq;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  int          wr_cyc_q [$];
  logic [31:0] wr_data_q[$];

  led_pattern_sequencer_if bus ();

  led_pattern_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr            (bus),
    .irq            (irq),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record PIO writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      wr_cyc_q.push_back(cyc);
      wr_data_q.push_back(pio_writedata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d, output int edge_cyc);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    edge_cyc       = cyc;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cyc_q.delete();
    wr_data_q.delete();
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    bus.address    = 4'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic load_table(input logic [31:0] period);
    int e;
    csr_write(4'd8,  32'h01, e);
    csr_write(4'd9,  32'h02, e);
    csr_write(4'd10, 32'h04, e);
    csr_write(4'd11, 32'h08, e);
    csr_write(4'd1,  period, e);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int e;
    apply_reset();
    assert_cnt++;
    if (pio_chipselect !== 1'b0) begin fail_cnt++; $display("FAIL reset_pio_cs: got %b expected 0", pio_chipselect); end
    assert_cnt++;
    if (pio_write_n !== 1'b1) begin fail_cnt++; $display("FAIL reset_pio_wn: got %b expected 1", pio_write_n); end
    assert_cnt++;
    if (pio_address !== 2'd0) begin fail_cnt++; $display("FAIL reset_pio_addr: got %h expected 0", pio_address); end
    assert_cnt++;
    if (pio_writedata !== 32'd0) begin fail_cnt++; $display("FAIL reset_pio_data: got %h expected 0", pio_writedata); end
    assert_cnt++;
    if (irq !== 1'b0) begin fail_cnt++; $display("FAIL reset_irq: got %b expected 0", irq); end
    csr_read(4'd0, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
    csr_read(4'd1, rd);
    assert_cnt++;
    if (rd !== 32'd1) begin fail_cnt++; $display("FAIL reset_period: got %h expected 1", rd); end
    csr_read(4'd2, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL reset_status: got %h expected 0", rd); end
    csr_read(4'd3, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL reset_manual: got %h expected 0", rd); end
    csr_read(4'd15, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL reset_pattern7: got %h expected 0", rd); end
    csr_write(4'd5, 32'hFFFF_FFFF, e);
    csr_read(4'd5, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL unmapped_read: got %h expected 0", rd); end
    csr_read(4'd0, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL unmapped_write_ctrl: got %h expected 0", rd); end
    assert_cnt++;
    if (wr_cyc_q.size() != 0) begin fail_cnt++; $display("FAIL reset_no_pio: got %0d writes expected 0", wr_cyc_q.size()); end
  endtask

  task automatic test_loop();
    logic [31:0] rd;
    logic [31:0] exp_data [5];
    int k, e;
    exp_data = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h01};
    apply_reset();
    load_table(32'd3);
    csr_write(4'd0, 32'h31, k);
    assert_cnt++;
    if (pio_chipselect !== 1'b1) begin fail_cnt++; $display("FAIL loop_first_cs: got %b expected 1", pio_chipselect); end
    wait_until(k + 2);
    csr_read(4'd2, rd);
    assert_cnt++;
    if (rd !== 32'h001) begin fail_cnt++; $display("FAIL loop_status_busy: got %h expected 001", rd); end
    assert_cnt++;
    if (irq !== 1'b0) begin fail_cnt++; $display("FAIL loop_irq: got %b expected 0", irq); end
    wait_until(k + 17);
    assert_cnt++;
    if (wr_cyc_q.size() != 5) begin fail_cnt++; $display("FAIL loop_count: got %0d expected 5", wr_cyc_q.size()); end
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (i >= wr_data_q.size()) begin
        fail_cnt++; $display("FAIL loop_write%0d: got none expected %h", i, exp_data[i]);
      end else if (wr_data_q[i] !== exp_data[i] || wr_cyc_q[i] != k + 4 * i) begin
        fail_cnt++;
        $display("FAIL loop_write%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, wr_data_q[i], wr_cyc_q[i], exp_data[i], k + 4 * i);
      end
    end
    csr_write(4'd0, 32'h0, e);
  endtask

  task automatic test_one_shot();
    logic [31:0] rd;
    logic [31:0] exp_data [4];
    int k, e;
    exp_data = '{32'h01, 32'h02, 32'h04, 32'h08};
    apply_reset();
    load_table(32'd3);
    csr_write(4'd0, 32'h33, k);
    wait_until(k + 16);
    assert_cnt++;
    if (irq !== 1'b0) begin fail_cnt++; $display("FAIL oneshot_irq_done_cycle: got %b expected 0", irq); end
    wait_until(k + 17);
    assert_cnt++;
    if (irq !== 1'b1) begin fail_cnt++; $display("FAIL oneshot_irq_set: got %b expected 1", irq); end
    wait_until(k + 30);
    assert_cnt++;
    if (wr_cyc_q.size() != 4) begin fail_cnt++; $display("FAIL oneshot_count: got %0d expected 4", wr_cyc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      assert_cnt++;
      if (i >= wr_data_q.size()) begin
        fail_cnt++; $display("FAIL oneshot_write%0d: got none expected %h", i, exp_data[i]);
      end else if (wr_data_q[i] !== exp_data[i] || wr_cyc_q[i] != k + 4 * i) begin
        fail_cnt++;
        $display("FAIL oneshot_write%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, wr_data_q[i], wr_cyc_q[i], exp_data[i], k + 4 * i);
      end
    end
    csr_read(4'd0, rd);
    assert_cnt++;
    if (rd !== 32'h32) begin fail_cnt++; $display("FAIL oneshot_ctrl: got %h expected 32", rd); end
    csr_read(4'd2, rd);
    assert_cnt++;
    if (rd !== 32'h130) begin fail_cnt++; $display("FAIL oneshot_status: got %h expected 130", rd); end
    csr_write(4'd2, 32'h100, e);
    assert_cnt++;
    if (irq !== 1'b0) begin fail_cnt++; $display("FAIL oneshot_irq_clear: got %b expected 0", irq); end
    csr_read(4'd2, rd);
    assert_cnt++;
    if (rd !== 32'h030) begin fail_cnt++; $display("FAIL oneshot_status_clear: got %h expected 030", rd); end
  endtask

  task automatic test_period_zero();
    logic [31:0] rd;
    logic [31:0] exp_data [4];
    int k, e;
    exp_data = '{32'hAA, 32'h55, 32'hAA, 32'h55};
    apply_reset();
    csr_write(4'd8, 32'hAA, e);
    csr_write(4'd9, 32'h55, e);
    csr_write(4'd1, 32'h0, e);
    csr_write(4'd0, 32'h11, k);
    wait_until(k + 7);
    assert_cnt++;
    if (wr_cyc_q.size() != 4) begin fail_cnt++; $display("FAIL period0_count: got %0d expected 4", wr_cyc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      assert_cnt++;
      if (i >= wr_data_q.size()) begin
        fail_cnt++; $display("FAIL period0_write%0d: got none expected %h", i, exp_data[i]);
      end else if (wr_data_q[i] !== exp_data[i] || wr_cyc_q[i] != k + 2 * i) begin
        fail_cnt++;
        $display("FAIL period0_write%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, wr_data_q[i], wr_cyc_q[i], exp_data[i], k + 2 * i);
      end
    end
    csr_write(4'd0, 32'h0, e);
    csr_read(4'd1, rd);
    assert_cnt++;
    if (rd !== 32'h0) begin fail_cnt++; $display("FAIL period0_readback: got %h expected 0", rd); end
  endtask

  task automatic test_disable();
    logic [31:0] rd;
    int k, e;
    apply_reset();
    load_table(32'd3);
    csr_write(4'd0, 32'h31, k);
    wait_until(k + 8);
    csr_write(4'd0, 32'h0, e);
    csr_read(4'd2, rd);
    assert_cnt++;
    if (rd !== 32'h020) begin fail_cnt++; $display("FAIL disable_status: got %h expected 020", rd); end
    assert_cnt++;
    if (irq !== 1'b0) begin fail_cnt++; $display("FAIL disable_irq: got %b expected 0", irq); end
    wait_until(k + 30);
    assert_cnt++;
    if (wr_cyc_q.size() != 3) begin fail_cnt++; $display("FAIL disable_count: got %0d expected 3", wr_cyc_q.size()); end
    assert_cnt++;
    if (wr_data_q.size() == 0 || wr_data_q[wr_data_q.size() - 1] !== 32'h04) begin
      fail_cnt++; $display("FAIL disable_last_pattern: got %0d writes expected last 04", wr_data_q.size());
    end
  endtask

  task automatic test_manual();
    logic [31:0] rd;
    logic [31:0] exp_data [5];
    int k, k2, e;
    exp_data = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h01};
    apply_reset();
    csr_write(4'd3, 32'h5A, k);
    assert_cnt++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_writedata !== 32'h0000005A) begin
      fail_cnt++;
      $display("FAIL manual_idle_write: got cs=%b wn=%b data=%h expected cs=1 wn=0 data=0000005a",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    wait_until(k + 5);
    assert_cnt++;
    if (wr_cyc_q.size() != 1) begin fail_cnt++; $display("FAIL manual_idle_count: got %0d expected 1", wr_cyc_q.size()); end
    csr_read(4'd3, rd);
    assert_cnt++;
    if (rd !== 32'h5A) begin fail_cnt++; $display("FAIL manual_readback: got %h expected 5a", rd); end
    load_table(32'd3);
    clear_log();
    csr_write(4'd0, 32'h31, k2);
    wait_until(k2 + 1);
    csr_write(4'd3, 32'hC3, e);
    wait_until(k2 + 18);
    assert_cnt++;
    if (wr_cyc_q.size() != 5) begin fail_cnt++; $display("FAIL manual_busy_count: got %0d expected 5", wr_cyc_q.size()); end
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (i >= wr_data_q.size()) begin
        fail_cnt++; $display("FAIL manual_busy_write%0d: got none expected %h", i, exp_data[i]);
      end else if (wr_data_q[i] !== exp_data[i] || wr_cyc_q[i] != k2 + 4 * i) begin
        fail_cnt++;
        $display("FAIL manual_busy_write%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, wr_data_q[i], wr_cyc_q[i], exp_data[i], k2 + 4 * i);
      end
    end
    csr_read(4'd3, rd);
    assert_cnt++;
    if (rd !== 32'h5A) begin fail_cnt++; $display("FAIL manual_busy_dropped: got %h expected 5a", rd); end
    csr_write(4'd0, 32'h0, e);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int k;
    apply_reset();
    load_table(32'd5);
    csr_write(4'd0, 32'h31, k);
    wait_until(k + 6);
    assert_cnt++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h02) begin
      fail_cnt++; $display("FAIL midreset_pre_write: got cs=%b data=%h expected cs=1 data=02", pio_chipselect, pio_writedata);
    end
    reset_n = 1'b0;
    #1;
    assert_cnt++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin
      fail_cnt++;
      $display("FAIL midreset_pio: got cs=%b wn=%b data=%h expected cs=0 wn=1 data=0",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    csr_read(4'd1, rd);
    assert_cnt++;
    if (rd !== 32'd1) begin fail_cnt++; $display("FAIL midreset_period: got %h expected 1", rd); end
    csr_read(4'd0, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL midreset_ctrl: got %h expected 0", rd); end
    csr_read(4'd9, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL midreset_pattern1: got %h expected 0", rd); end
    csr_read(4'd2, rd);
    assert_cnt++;
    if (rd !== 32'd0) begin fail_cnt++; $display("FAIL midreset_status: got %h expected 0", rd); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    repeat (12) @(negedge clk);
    assert_cnt++;
    if (wr_cyc_q.size() != 0) begin fail_cnt++; $display("FAIL midreset_idle_after: got %0d writes expected 0", wr_cyc_q.size()); end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.address    = 4'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    test_reset();
    test_loop();
    test_one_shot();
    test_period_zero();
    test_disable();
    test_manual();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
